// File: rtl/serial_or_reduce.sv
// serial_or_reduce
//   Folds a packet of WIDTH-bit beats into one word: the bitwise OR of
//   every beat in the packet. The result sits on a registered valid/ready
//   output until it is consumed. A packet longer than MAX_BEATS still
//   accumulates to its last beat, but the result is marked with down_ovf.
//
// Optional feature macro: SERIAL_OR_REDUCE_CNT_EN
//   When defined, a down_beats port carries the packet's beat count,
//   which saturates at MAX_BEATS.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   up_valid   in   input beat valid
//   up_ready   out  a beat is accepted this cycle (combinational)
//   up_data    in   input beat [WIDTH]
//   up_last    in   final beat of the packet
//   down_valid out  result valid
//   down_ready in   consumer takes the result
//   down_data  out  OR of all beats of the packet [WIDTH]
//   down_ovf   out  the packet was longer than MAX_BEATS
//   down_beats out  beat count [$clog2(MAX_BEATS+1)] (only with the macro)
module serial_or_reduce #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  input  logic             up_last,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [WIDTH-1:0] down_data,
  output logic             down_ovf
`ifdef SERIAL_OR_REDUCE_CNT_EN
  ,output logic [$clog2(MAX_BEATS+1)-1:0] down_beats
`endif
);

  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BEATS);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             ovf_reg, ovf_next;
  logic             first_reg;
  logic [WIDTH-1:0] res_data_reg;
  logic             res_ovf_reg;
  logic             beat;

  // In HOLD a new beat is only taken when the pending result leaves in the
  // same cycle, so the result registers never change while they are stalled.
  assign up_ready = (state_reg == ACCUM) || ((state_reg == HOLD) && down_ready);
  assign beat     = up_valid && up_ready;

  assign down_valid = (state_reg == HOLD);
  assign down_data  = res_data_reg;
  assign down_ovf   = res_ovf_reg;

  // Accumulator update for an accepted beat. The first beat of a packet
  // restarts the fold, so nothing from a previous packet can leak in.
  always_comb begin
    acc_next = acc_reg;
    cnt_next = cnt_reg;
    ovf_next = ovf_reg;
    if (first_reg) begin
      acc_next = up_data;
      cnt_next = CW'(1);
      ovf_next = 1'b0;
    end else begin
      acc_next = acc_reg | up_data;
      // A beat arriving with the count already at MAX_BEATS is one too many.
      cnt_next = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + CW'(1);
      ovf_next = ovf_reg | (cnt_reg == CNT_MAX);
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ACCUM: begin
        if (beat && up_last) state_next = HOLD;
      end
      HOLD: begin
        // Result consumed; stay in HOLD only if a new packet ends right now.
        if (down_ready) state_next = (beat && up_last) ? HOLD : ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ACCUM;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg      <= '0;
      cnt_reg      <= '0;
      ovf_reg      <= 1'b0;
      first_reg    <= 1'b1;
      res_data_reg <= '0;
      res_ovf_reg  <= 1'b0;
    end else if (beat) begin
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      ovf_reg   <= ovf_next;
      first_reg <= up_last;
      if (up_last) begin
        res_data_reg <= acc_next;
        res_ovf_reg  <= ovf_next;
      end
    end
  end

`ifdef SERIAL_OR_REDUCE_CNT_EN
  logic [CW-1:0] res_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  res_cnt_reg <= '0;
    else if (beat && up_last) res_cnt_reg <= cnt_next;
  end

  assign down_beats = res_cnt_reg;
`else
  // Without the count port, cnt_reg serves only overflow detection.
`endif

endmodule

// File: tb/tb_serial_or_reduce.sv
module tb_serial_or_reduce;

  localparam int WIDTH     = 8;
  localparam int MAX_BEATS = 16;
  localparam int CW        = $clog2(MAX_BEATS + 1);

  logic             clk;
  logic             rst;
  logic             up_valid;
  logic             up_ready;
  logic [WIDTH-1:0] up_data;
  logic             up_last;
  logic             down_valid;
  logic             down_ready;
  logic [WIDTH-1:0] down_data;
  logic             down_ovf;
`ifdef SERIAL_OR_REDUCE_CNT_EN
  logic [CW-1:0]    down_beats;
`endif

  int checks = 0;
  int errors = 0;

  serial_or_reduce #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .up_last    (up_last),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data),
    .down_ovf   (down_ovf)
`ifdef SERIAL_OR_REDUCE_CNT_EN
    ,.down_beats (down_beats)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one cycle of inputs, clock it, sample 1 time unit after the edge.
  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic l);
    up_valid = v;
    up_data  = d;
    up_last  = l;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; up_valid = 1'b0; up_data = '0; up_last = 1'b0; down_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL reset_up_ready got=%b exp=1", up_ready); end
    checks++; if (down_valid !== 1'b0) begin errors++; $display("FAIL reset_down_valid got=%b exp=0", down_valid); end
    checks++; if (down_data !== 8'h00) begin errors++; $display("FAIL reset_down_data got=%h exp=00", down_data); end
    checks++; if (down_ovf !== 1'b0) begin errors++; $display("FAIL reset_down_ovf got=%b exp=0", down_ovf); end
`ifdef SERIAL_OR_REDUCE_CNT_EN
    checks++; if (down_beats !== CW'(0)) begin errors++; $display("FAIL reset_down_beats got=%0d exp=0", down_beats); end
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    down_ready = 1'b1;
    drive(1'b1, 8'h01, 1'b0);
    drive(1'b1, 8'h04, 1'b0);
    checks++; if (down_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", down_valid); end
    drive(1'b1, 8'h80, 1'b1);
    checks++; if (down_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", down_valid); end
    checks++; if (down_data !== 8'h85) begin errors++; $display("FAIL basic_data got=%h exp=85", down_data); end
    checks++; if (down_ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got=%b exp=0", down_ovf); end
`ifdef SERIAL_OR_REDUCE_CNT_EN
    checks++; if (down_beats !== CW'(3)) begin errors++; $display("FAIL basic_beats got=%0d exp=3", down_beats); end
`endif
    drive(1'b0, 8'h00, 1'b0);
    checks++; if (down_valid !== 1'b0) begin errors++; $display("FAIL basic_consumed got=%b exp=0", down_valid); end
    $display("test_basic: packet 01,04,80 -> %h", 8'h85);
  endtask

  task automatic test_single_and_zero();
    down_ready = 1'b1;
    drive(1'b1, 8'h3C, 1'b1);
    checks++; if (down_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", down_valid); end
    checks++; if (down_data !== 8'h3C) begin errors++; $display("FAIL single_data got=%h exp=3c", down_data); end
`ifdef SERIAL_OR_REDUCE_CNT_EN
    checks++; if (down_beats !== CW'(1)) begin errors++; $display("FAIL single_beats got=%0d exp=1", down_beats); end
`endif
    drive(1'b1, 8'h00, 1'b0);
    drive(1'b1, 8'h00, 1'b0);
    checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL zero_up_ready got=%b exp=1", up_ready); end
    drive(1'b1, 8'h00, 1'b1);
    checks++; if (down_valid !== 1'b1) begin errors++; $display("FAIL zero_valid got=%b exp=1", down_valid); end
    checks++; if (down_data !== 8'h00) begin errors++; $display("FAIL zero_data got=%h exp=00", down_data); end
    drive(1'b0, 8'h00, 1'b0);
    $display("test_single_and_zero: 3c -> 3c, zeros -> 00");
  endtask

  task automatic test_backpressure();
    down_ready = 1'b1;
    drive(1'b1, 8'h21, 1'b1);
    checks++; if (down_data !== 8'h21) begin errors++; $display("FAIL bp_first_data got=%h exp=21", down_data); end
    down_ready = 1'b0;
    up_valid = 1'b1; up_data = 8'h10; up_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (up_ready !== 1'b0) begin errors++; $display("FAIL bp_up_ready cyc=%0d got=%b exp=0", i, up_ready); end
      @(posedge clk);
      #1;
      checks++; if (down_valid !== 1'b1 || down_data !== 8'h21) begin
        errors++; $display("FAIL bp_stable cyc=%0d got=%b/%h exp=1/21", i, down_valid, down_data);
      end
    end
    down_ready = 1'b1;
    #1;
    checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", up_ready); end
    @(posedge clk);
    #1;
    checks++; if (down_valid !== 1'b1 || down_data !== 8'h10) begin
      errors++; $display("FAIL bp_new_result got=%b/%h exp=1/10", down_valid, down_data);
    end
    drive(1'b0, 8'h00, 1'b0);
    $display("test_backpressure: 21 held 5 cycles, then 10");
  endtask

  task automatic test_overflow();
    down_ready = 1'b1;
    // Exactly MAX_BEATS beats: no overflow.
    for (int i = 0; i < MAX_BEATS; i++) drive(1'b1, 8'h01, i == MAX_BEATS - 1);
    checks++; if (down_data !== 8'h01 || down_ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_exact got=%h/%b exp=01/0", down_data, down_ovf);
    end
`ifdef SERIAL_OR_REDUCE_CNT_EN
    checks++; if (down_beats !== CW'(16)) begin errors++; $display("FAIL ovf_exact_beats got=%0d exp=16", down_beats); end
`endif
    drive(1'b0, 8'h00, 1'b0);
    // 18 beats, beat 17 carries 0x02.
    for (int i = 0; i < 18; i++) drive(1'b1, (i == 16) ? 8'h02 : 8'h00, i == 17);
    checks++; if (down_valid !== 1'b1 || down_data !== 8'h02) begin
      errors++; $display("FAIL ovf_data got=%b/%h exp=1/02", down_valid, down_data);
    end
    checks++; if (down_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", down_ovf); end
`ifdef SERIAL_OR_REDUCE_CNT_EN
    checks++; if (down_beats !== CW'(16)) begin errors++; $display("FAIL ovf_beats got=%0d exp=16", down_beats); end
`endif
    drive(1'b0, 8'h00, 1'b0);
    $display("test_overflow: 16 beats ovf=0, 18 beats ovf=1 data=02");
  endtask

  task automatic test_back_to_back();
    logic [7:0] d_tab [6] = '{8'h11, 8'h22, 8'h40, 8'h01, 8'h02, 8'h08};
    logic       l_tab [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] e_tab [6] = '{8'h00, 8'h33, 8'h40, 8'h00, 8'h00, 8'h0B};
    int         n_tab [6] = '{0, 2, 1, 0, 0, 3};
    down_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      up_valid = 1'b1; up_data = d_tab[i]; up_last = l_tab[i];
      #1;
      checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready beat=%0d got=%b exp=1", i, up_ready); end
      @(posedge clk);
      #1;
      checks++; if (down_valid !== l_tab[i]) begin errors++; $display("FAIL b2b_valid beat=%0d got=%b exp=%b", i, down_valid, l_tab[i]); end
      if (l_tab[i]) begin
        checks++; if (down_data !== e_tab[i]) begin errors++; $display("FAIL b2b_data beat=%0d got=%h exp=%h", i, down_data, e_tab[i]); end
`ifdef SERIAL_OR_REDUCE_CNT_EN
        checks++; if (down_beats !== CW'(n_tab[i])) begin errors++; $display("FAIL b2b_beats beat=%0d got=%0d exp=%0d", i, down_beats, n_tab[i]); end
`endif
        $display("test_back_to_back: packet ending at beat %0d -> %h (%0d beats)", i, e_tab[i], n_tab[i]);
      end
    end
    drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset_mid();
    down_ready = 1'b1;
    drive(1'b1, 8'hFF, 1'b0);
    drive(1'b1, 8'h0F, 1'b0);
    up_valid = 1'b0;
    rst = 1'b1;
    #2;
    checks++; if (down_valid !== 1'b0 || up_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_outputs got=%b/%b exp=0/1", down_valid, up_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive(1'b1, 8'h40, 1'b1);
    checks++; if (down_valid !== 1'b1 || down_data !== 8'h40) begin
      errors++; $display("FAIL rstmid_data got=%b/%h exp=1/40", down_valid, down_data);
    end
`ifdef SERIAL_OR_REDUCE_CNT_EN
    checks++; if (down_beats !== CW'(1)) begin errors++; $display("FAIL rstmid_beats got=%0d exp=1", down_beats); end
`endif
    // Reset while a result is stalled in HOLD.
    down_ready = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    #2;
    checks++; if (down_valid !== 1'b0 || down_data !== 8'h00 || down_ovf !== 1'b0) begin
      errors++; $display("FAIL rsthold_outputs got=%b/%h/%b exp=0/00/0", down_valid, down_data, down_ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    down_ready = 1'b1;
    @(posedge clk);
    #1;
    $display("test_reset_mid: post-reset packet 40 -> 40");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single_and_zero();
    test_backpressure();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_or_reduce.md
# serial_or_reduce

Streaming accumulator that takes a packet of WIDTH-bit words over a valid/ready handshake and produces one word per packet: the bitwise OR of every beat in that packet. It sits directly downstream of the per-bit mux-built OR gates and folds their per-cycle results over time into a packet-level "any bit ever set" summary. The result is held on a registered valid/ready output until it is consumed.

## Interface
- WIDTH, 8: data width of input beats and of the result.
- MAX_BEATS, 16: maximum legal packet length in beats, >= 1.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- up_valid  input  1  input beat valid.
- up_ready  output  1  block accepts a beat this cycle.
- up_data  input  WIDTH  input beat.
- up_last  input  1  beat is the final beat of its packet.
- down_valid  output  1  result valid.
- down_ready  input  1  consumer accepts the result.
- down_data  output  WIDTH  OR of all beats of the packet.
- down_ovf  output  1  packet exceeded MAX_BEATS beats.
- down_beats  output  $clog2(MAX_BEATS+1)  beat count; exists only with SERIAL_OR_REDUCE_CNT_EN.

## Operation
- Two states: ACCUM and HOLD. Reset enters ACCUM.
- Beat accepted when up_valid && up_ready.
- up_ready = (state == ACCUM) || (state == HOLD && down_ready).
- Internal acc[WIDTH], cnt (saturating), ovf, first flag (set after reset and after each last beat).
- Accepted beat with first set: acc <= up_data, cnt <= 1, ovf <= 0. Otherwise acc <= acc | up_data, cnt <= min(cnt+1, MAX_BEATS), ovf <= ovf | (cnt == MAX_BEATS).
- Accepted beat with up_last: result registers load the final acc/cnt/ovf values (including this beat), state -> HOLD, first set.
- HOLD with down_ready and no accepted beat: state -> ACCUM, down_valid drops.
- HOLD with down_ready and an accepted beat: old result consumed; new beat processed as above (last -> stay HOLD with new result; not last -> ACCUM).
- Single-beat packet (first beat has up_last): down_data = up_data, cnt = 1.
- ovf never terminates a packet; accumulation continues, cnt stays at MAX_BEATS.
- down_data/down_ovf/down_beats stable while down_valid && !down_ready.

## Timing
- Reset values: up_ready 1, down_valid 0, down_data 0, down_ovf 0, down_beats 0, acc 0, cnt 0, first 1.
- Latency: down_valid rises the cycle after the last beat is accepted.
- Throughput: one beat per cycle sustained; no bubble between packets when down_ready is high in HOLD.
- up_ready is combinational from state and down_ready; no other combinational path from inputs to outputs.
- Reset asserted mid-packet or in HOLD: partial packet and pending result discarded immediately; outputs at reset values while rst is high.
- up_valid without up_ready: no state change; upstream holds its beat.

## Configuration
- SERIAL_OR_REDUCE_CNT_EN defined: down_beats port present, driven by the registered count (saturating at MAX_BEATS).
- Not defined: port absent; cnt still kept internally to generate down_ovf.

## Test plan
- Reset, then packet 0x01, 0x04, 0x80(last), down_ready=1 -> one cycle after last, down_valid=1, down_data=0x85, down_ovf=0, down_beats=3.
- Single beat 0x3C with up_last -> down_data=0x3C, down_beats=1; all-zero beats -> down_data=0x00.
- Result pending, down_ready=0 for 5 cycles -> up_ready=0, down_data stable; raise down_ready with new beat 0x10(last) presented -> old result consumed, next cycle down_data=0x10.
- MAX_BEATS=16, 18 beats of 0x00 with beat 17 = 0x02 -> down_data=0x02, down_ovf=1, down_beats=16.
- Back-to-back packets with down_ready=1 continuously -> up_ready stays 1, one result per packet, no lost beats.
- Assert rst after 2 beats of a packet, then send 0x40(last) -> down_data=0x40 (no leakage from earlier beats), down_beats=1.
